// File: rtl/control_pkg.sv
// Shared decode constants for the control unit, the ALU and benches.
// Holds the opcode encodings, ALU operation codes and the flag bundle type.
package control_pkg;

    localparam logic [6:0] op_rtype  = 7'b0110011;
    localparam logic [6:0] op_itype  = 7'b0010011;
    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_branch = 7'b1100011;

    localparam logic [3:0] alu_and  = 4'b0000;
    localparam logic [3:0] alu_or   = 4'b0001;
    localparam logic [3:0] alu_add  = 4'b0010;
    localparam logic [3:0] alu_xor  = 4'b0011;
    localparam logic [3:0] alu_sll  = 4'b0100;
    localparam logic [3:0] alu_srl  = 4'b0101;
    localparam logic [3:0] alu_sub  = 4'b0110;
    localparam logic [3:0] alu_sra  = 4'b0111;
    localparam logic [3:0] alu_slt  = 4'b1000;
    localparam logic [3:0] alu_sltu = 4'b1001;

    // ALU operation class handed from the main decoder to alu_decoder
    typedef enum logic [1:0] {
        aluop_add   = 2'b00,
        aluop_sub   = 2'b01,
        aluop_rtype = 2'b10,
        aluop_itype = 2'b11
    } aluop_e;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memtoreg;
        logic memwrite;
        logic alusrc;
        logic regwrite;
    } ctrl_flags_t;

    function automatic ctrl_flags_t nop_flags();
        ctrl_flags_t f;
        f = '0;
        return f;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus funct3/funct7[5] onto a 4-bit ALU control code.
// Purely combinational; the result is registered by the enclosing control unit.
module alu_decoder
    import control_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alucontrol_o
);

    logic [3:0] funct_op;
    logic       is_rtype;

    assign is_rtype = (aluop_i == aluop_rtype);

    // funct7[5] only distinguishes SUB in R-type and SRA in both R- and I-type
    always_comb begin
        funct_op = alu_add;
        unique case (funct3_i)
            3'b000:  funct_op = (is_rtype && funct7b5_i) ? alu_sub : alu_add;
            3'b001:  funct_op = alu_sll;
            3'b010:  funct_op = alu_slt;
            3'b011:  funct_op = alu_sltu;
            3'b100:  funct_op = alu_xor;
            3'b101:  funct_op = funct7b5_i ? alu_sra : alu_srl;
            3'b110:  funct_op = alu_or;
            3'b111:  funct_op = alu_and;
            default: funct_op = alu_add;
        endcase
    end

    always_comb begin
        alucontrol_o = alu_add;
        unique case (aluop_i)
            aluop_add:   alucontrol_o = alu_add;
            aluop_sub:   alucontrol_o = alu_sub;
            aluop_rtype: alucontrol_o = funct_op;
            aluop_itype: alucontrol_o = funct_op;
            default:     alucontrol_o = alu_add;
        endcase
    end

endmodule

// File: rtl/control.sv
// Main instruction decoder with a one-cycle registered output stage.
// Flags and ALU class come from the opcode; alu_decoder refines the ALU code.
module control
    import control_pkg::*;
(
    input  logic [31:0] A,
    input  logic        reset,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic [3:0]  ALUControl,
    output logic        ALUSrc,
    output logic        RegWrite,
    input  logic        clk
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    ctrl_flags_t dec_flags;
    aluop_e      dec_aluop;
    logic [3:0]  dec_alucontrol;

    ctrl_flags_t flags_q;
    ctrl_flags_t flags_d;
    logic [3:0]  alucontrol_q;
    logic [3:0]  alucontrol_d;

    assign opcode   = A[6:0];
    assign funct3   = A[14:12];
    assign funct7b5 = A[30];

    logic unused_abits;
    assign unused_abits = ^{A[31], A[29:15], A[11:7]};

    always_comb begin
        dec_flags = nop_flags();
        dec_aluop = aluop_add;
        case (opcode)
            op_rtype: begin
                dec_flags.regwrite = 1'b1;
                dec_aluop          = aluop_rtype;
            end
            op_itype: begin
                dec_flags.regwrite = 1'b1;
                dec_flags.alusrc   = 1'b1;
                dec_aluop          = aluop_itype;
            end
            op_load: begin
                dec_flags.regwrite = 1'b1;
                dec_flags.alusrc   = 1'b1;
                dec_flags.memread  = 1'b1;
                dec_flags.memtoreg = 1'b1;
            end
            op_store: begin
                dec_flags.memwrite = 1'b1;
                dec_flags.alusrc   = 1'b1;
            end
            op_branch: begin
                dec_flags.branch = 1'b1;
                dec_aluop        = aluop_sub;
            end
            default: begin
                dec_flags = nop_flags();
                dec_aluop = aluop_add;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i      (dec_aluop),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .alucontrol_o (dec_alucontrol)
    );

    assign flags_d      = dec_flags;
    assign alucontrol_d = dec_alucontrol;

    // Reset forces the NOP decode so nothing decoded during reset survives it
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q      <= nop_flags();
            alucontrol_q <= alu_add;
        end else begin
            flags_q      <= flags_d;
            alucontrol_q <= alucontrol_d;
        end
    end

    assign Branch     = flags_q.branch;
    assign MemRead    = flags_q.memread;
    assign MemtoReg   = flags_q.memtoreg;
    assign MemWrite   = flags_q.memwrite;
    assign ALUSrc     = flags_q.alusrc;
    assign RegWrite   = flags_q.regwrite;
    assign ALUControl = alucontrol_q;

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: stimulus pushes expected outputs from a
// rule-level model, a monitor pops and compares one cycle after each edge.
module tb_control;
    import control_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic        Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [3:0]  ALUControl;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [9:0]  exp;
        logic [31:0] a;
        logic        rst_n;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    control dut (
        .A          (A),
        .reset      (reset),
        .Branch     (Branch),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .MemWrite   (MemWrite),
        .ALUControl (ALUControl),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .clk        (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {Branch,MemRead,MemtoReg,MemWrite,ALUControl,ALUSrc,RegWrite}
    function automatic logic [9:0] model(input logic rst_n, input logic [31:0] a);
        logic [3:0] f3map [8];
        logic [3:0] alu;
        logic [2:0] f3;
        logic       br, mr, m2r, mw, src, rw;
        f3map = '{alu_add, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_or, alu_and};
        f3 = a[14:12];
        {br, mr, m2r, mw, src, rw} = 6'b0;
        alu = alu_add;
        if (rst_n) begin
            if (a[6:0] == op_rtype || a[6:0] == op_itype) begin
                rw  = 1'b1;
                src = (a[6:0] == op_itype);
                alu = f3map[f3];
                if (f3 == 3'd5 && a[30]) alu = alu_sra;
                if (f3 == 3'd0 && a[30] && a[6:0] == op_rtype) alu = alu_sub;
            end else if (a[6:0] == op_load) begin
                {rw, src, mr, m2r} = 4'b1111;
            end else if (a[6:0] == op_store) begin
                {mw, src} = 2'b11;
            end else if (a[6:0] == op_branch) begin
                br  = 1'b1;
                alu = alu_sub;
            end
        end
        return {br, mr, m2r, mw, alu, src, rw};
    endfunction

    task automatic step(input logic rst_n, input logic [31:0] a);
        sb_entry_t e;
        reset   = rst_n;
        A       = a;
        e.exp   = model(rst_n, a);
        e.a     = a;
        e.rst_n = rst_n;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge
    initial begin
        sb_entry_t e;
        logic [9:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {Branch, MemRead, MemtoReg, MemWrite, ALUControl, ALUSrc, RegWrite};
                n_checks++;
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL decode A=%08h rst_n=%0b got=%b expected=%b",
                             e.a, e.rst_n, got, e.exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ops [6];
        logic [31:0] a;
        n_checks = 0;
        n_fail   = 0;
        ops = '{op_rtype, op_itype, op_load, op_store, op_branch, 7'b0};

        step(1'b0, 32'h0020_8133);
        step(1'b0, 32'h0020_8133);
        step(1'b1, 32'h0000_8133);
        step(1'b1, 32'h4000_8133);
        step(1'b1, 32'h0000_F133);
        step(1'b1, 32'h0000_E133);
        step(1'b1, 32'h0000_E103);
        step(1'b1, 32'h0000_E123);
        step(1'b1, 32'h0000_E163);
        step(1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h0000_0000);
        step(1'b0, 32'h0000_8133);
        step(1'b1, 32'h0000_8133);
        // I-type funct7[5] only matters for shifts
        step(1'b1, 32'h4000_0113);
        step(1'b1, 32'h4000_5113);
        step(1'b1, 32'h0000_5113);
        step(1'b1, 32'h4000_5133);

        for (int i = 0; i < 400; i++) begin
            a = $urandom();
            if ($urandom_range(0, 7) != 0) a[6:0] = ops[$urandom_range(0, 5)];
            step(($urandom_range(0, 15) != 0), a);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
